// File: rtl/rbus_line_buffer.sv
// Per-lane circular line buffer fed by one reconfigurable-bus output lane.
// Holds one activation row with a run-time wrap point and supports replay via read-pointer clear.
module rbus_line_buffer #(
    parameter int BITWIDTH_DATA = 8,
    parameter int BITWIDTH_ADDR = 8
) (
    input  logic                     RLB_Clk,
    input  logic                     RLB_Reset,
    input  logic [BITWIDTH_ADDR-1:0] RLB_Length,
    input  logic                     RLB_SetEn,
    input  logic [BITWIDTH_DATA-1:0] RLB_Data_In,
    input  logic                     RLB_OEn,
    input  logic                     RLB_Wptclr,
    input  logic                     RLB_Rptclr,
    output logic [BITWIDTH_DATA-1:0] RLB_Data_Out,
    output logic                     RLB_Data_Valid,
    output logic [BITWIDTH_ADDR:0]   RLB_Count,
    output logic                     RLB_Empty,
    output logic                     RLB_Full,
    output logic                     RLB_Overflow,
    output logic                     RLB_Underflow
);

    localparam int DEPTH = 2 ** BITWIDTH_ADDR;

    logic [BITWIDTH_DATA-1:0] mem [DEPTH];

    logic [BITWIDTH_ADDR-1:0] wptr_q, wptr_d;
    logic [BITWIDTH_ADDR-1:0] rptr_q, rptr_d;
    logic [BITWIDTH_ADDR:0]   count_q, count_d;
    logic [BITWIDTH_DATA-1:0] dataOut_q, dataOut_d;
    logic                     valid_q, valid_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;

    logic [BITWIDTH_ADDR:0]   lenPlusOne;
    logic                     clearCycle;
    logic                     isEmpty;
    logic                     isFull;
    logic                     readAcc;
    logic                     writeAcc;

    function automatic logic [BITWIDTH_ADDR-1:0] advancePtr(input logic [BITWIDTH_ADDR-1:0] p,
                                                           input logic [BITWIDTH_ADDR-1:0] last);
        if (p == last) begin
            return '0;
        end
        return p + BITWIDTH_ADDR'(1);
    endfunction

    assign lenPlusOne = {1'b0, RLB_Length} + (BITWIDTH_ADDR+1)'(1);
    assign clearCycle = RLB_Wptclr | RLB_Rptclr;
    assign isEmpty    = (count_q == '0);
    assign isFull     = (count_q == lenPlusOne);

    // A full buffer still accepts a write when a read frees a slot in the same cycle.
    assign readAcc  = !clearCycle && RLB_OEn && !isEmpty;
    assign writeAcc = !clearCycle && RLB_SetEn && ((count_q < lenPlusOne) || readAcc);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        dataOut_d   = dataOut_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clearCycle) begin
            if (RLB_Wptclr) begin
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
            end else begin
                // Replay covers entries written since the last write clear; a wrapped row reads as empty.
                rptr_d  = '0;
                count_d = {1'b0, wptr_q};
            end
            if (RLB_Wptclr && RLB_Rptclr) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
        end else begin
            if (readAcc) begin
                dataOut_d = mem[rptr_q];
                valid_d   = 1'b1;
                rptr_d    = advancePtr(rptr_q, RLB_Length);
            end
            if (writeAcc) begin
                wptr_d = advancePtr(wptr_q, RLB_Length);
            end
            if (writeAcc && !readAcc) begin
                count_d = count_q + (BITWIDTH_ADDR+1)'(1);
            end else if (readAcc && !writeAcc) begin
                count_d = count_q - (BITWIDTH_ADDR+1)'(1);
            end
            if (RLB_OEn && isEmpty) begin
                underflow_d = 1'b1;
            end
            if (RLB_SetEn && !writeAcc) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge RLB_Clk or negedge RLB_Reset) begin
        if (!RLB_Reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            dataOut_q   <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            dataOut_q   <= dataOut_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; pointers alone define what is reachable.
    always_ff @(posedge RLB_Clk) begin
        if (writeAcc) begin
            mem[wptr_q] <= RLB_Data_In;
        end
    end

    assign RLB_Data_Out   = dataOut_q;
    assign RLB_Data_Valid = valid_q;
    assign RLB_Count      = count_q;
    assign RLB_Empty      = isEmpty;
    assign RLB_Full       = isFull;
    assign RLB_Overflow   = overflow_q;
    assign RLB_Underflow  = underflow_q;

endmodule
